// File: rtl/branch_resolve_pkg.sv
// branch_resolve_pkg: shared EX-stage branch definitions.
//   ST_* : redirect FSM state encoding
//   WORD_SHIFT, JREG_HI/JREG_LO : word-offset shift and jump-region field
//   br_offset() : sign-extended branch word offset as a byte offset
package branch_resolve_pkg;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_PEND  = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;
   localparam int WORD_SHIFT = 2;
   localparam int JREG_HI = 31;
   localparam int JREG_LO = 28;
   function automatic logic [31:0] br_offset(input logic [15:0] imm);
      return {{16{imm[15]}}, imm} << WORD_SHIFT;
   endfunction
endpackage

// File: rtl/branch_target_gen.sv
// branch_target_gen: combinational redirect target mux (jr > jump > branch).
//   pc, imm16, target26, rs : instruction PC, branch offset, jump index, jr register
//   is_jump, is_jr          : type select; neither set means conditional branch
//   target                  : redirect address (jr target word-aligned)
module branch_target_gen
   import branch_resolve_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [15:0] imm16,
   input  logic [25:0] target26,
   input  logic [31:0] rs,
   input  logic        is_jump,
   input  logic        is_jr,
   output logic [31:0] target
);
   logic [31:0] pc4;
   assign pc4 = pc + 32'd4;
   // a misaligned jr still redirects, to the enclosing word
   assign target = is_jr   ? (rs & 32'hFFFF_FFFC) :
                   is_jump ? {pc4[JREG_HI:JREG_LO], target26, 2'b00} :
                             pc4 + br_offset(imm16);
endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: EX-stage branch resolution, redirect handshake, flush and stats.
//   clk, reset (async active-low)
//   ex_* / cmp_s             : EX instruction and Compare flag
//   redir_valid/ready/pc     : redirect handshake to the PC unit
//   ex_stall, flush          : hold EX while busy; kill wrong-path slot
//   addr_err, clr_stats      : sticky misaligned-jr flag; sync stats clear
//   br_cnt, taken_cnt        : saturating resolved/redirect counters
module branch_resolve
   import branch_resolve_pkg::*;
#(
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ex_valid,
   input  logic             ex_is_branch,
   input  logic             ex_is_jump,
   input  logic             ex_is_jr,
   input  logic [31:0]      ex_pc,
   input  logic [15:0]      ex_imm16,
   input  logic [25:0]      ex_target26,
   input  logic [31:0]      ex_rs,
   input  logic             cmp_s,
   output logic             redir_valid,
   input  logic             redir_ready,
   output logic [31:0]      redir_pc,
   output logic             ex_stall,
   output logic             flush,
   output logic             addr_err,
   input  logic             clr_stats,
   output logic [CNT_W-1:0] br_cnt,
   output logic [CNT_W-1:0] taken_cnt
);
   localparam int FW = $clog2(FLUSH_CYCLES + 2);
   logic [1:0] state;
   logic [FW-1:0] fcnt;
   logic [31:0] target;
   logic ctl, taken;
   branch_target_gen u_tgen (
      .pc(ex_pc),
      .imm16(ex_imm16),
      .target26(ex_target26),
      .rs(ex_rs),
      .is_jump(ex_is_jump),
      .is_jr(ex_is_jr),
      .target(target)
   );
   // EX inputs only matter in IDLE; ex_stall holds them upstream otherwise
   assign ctl = state == ST_IDLE && ex_valid && (ex_is_branch || ex_is_jump || ex_is_jr);
   assign taken = ex_is_jr || ex_is_jump || (ex_is_branch && cmp_s);
   assign redir_valid = state == ST_PEND;
   assign flush = state == ST_FLUSH;
   assign ex_stall = state != ST_IDLE;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         fcnt <= '0;
         redir_pc <= '0;
      end else begin
         case (state)
            ST_IDLE: if (ctl && taken) begin
               redir_pc <= target;
               state <= ST_PEND;
            end
            ST_PEND: if (redir_ready) begin
               state <= FLUSH_CYCLES > 0 ? ST_FLUSH : ST_IDLE;
               fcnt <= FW'(FLUSH_CYCLES);
            end
            ST_FLUSH: begin
               fcnt <= fcnt - FW'(1);
               if (fcnt <= FW'(1)) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         br_cnt <= '0;
         taken_cnt <= '0;
         addr_err <= 1'b0;
      end else if (clr_stats) begin
         br_cnt <= '0;
         taken_cnt <= '0;
         addr_err <= 1'b0;
      end else begin
         if (ctl && br_cnt != '1) br_cnt <= br_cnt + CNT_W'(1);
         if (ctl && taken && taken_cnt != '1) taken_cnt <= taken_cnt + CNT_W'(1);
         if (ctl && ex_is_jr && ex_rs[1:0] != 2'b00) addr_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed and randomized self-checking bench for branch_resolve.
module tb_branch_resolve;
   localparam int FC = 1;
   localparam int CW = 4;
   localparam int MAXC = 2 ** CW - 1;
   logic clk = 1'b0, reset = 1'b0;
   logic ex_valid = 0, ex_is_branch = 0, ex_is_jump = 0, ex_is_jr = 0, cmp_s = 0;
   logic [31:0] ex_pc = 0, ex_rs = 0;
   logic [15:0] ex_imm16 = 0;
   logic [25:0] ex_target26 = 0;
   logic redir_ready = 0, clr_stats = 0;
   logic redir_valid, ex_stall, flush, addr_err;
   logic [31:0] redir_pc;
   logic [CW-1:0] br_cnt, taken_cnt;
   int checks = 0, failures = 0;
   int exp_br = 0, exp_tk = 0;
   bit exp_ae = 0;
   logic [31:0] exp_pc = 0;

   branch_resolve #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
      .ex_is_jump(ex_is_jump), .ex_is_jr(ex_is_jr), .ex_pc(ex_pc), .ex_imm16(ex_imm16),
      .ex_target26(ex_target26), .ex_rs(ex_rs), .cmp_s(cmp_s), .redir_valid(redir_valid),
      .redir_ready(redir_ready), .redir_pc(redir_pc), .ex_stall(ex_stall), .flush(flush),
      .addr_err(addr_err), .clr_stats(clr_stats), .br_cnt(br_cnt), .taken_cnt(taken_cnt)
   );

   always #5 clk = ~clk;

   function automatic int sat(input int x);
      return x < MAXC ? x + 1 : x;
   endfunction

   function automatic logic [31:0] ref_target(input bit j, input bit r, input logic [31:0] pc,
                                              input logic [15:0] imm, input logic [25:0] t26,
                                              input logic [31:0] rs);
      logic [31:0] pc4;
      pc4 = pc + 32'd4;
      if (r) return rs & 32'hFFFF_FFFC;
      if (j) return (pc4 & 32'hF000_0000) | ({6'd0, t26} * 32'd4);
      return pc4 + 32'($signed(imm) * 4);
   endfunction

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic present(input bit b, input bit j, input bit r, input logic [31:0] pc,
                          input logic [15:0] imm, input logic [25:0] t26,
                          input logic [31:0] rs, input bit s);
      ex_valid = 1; ex_is_branch = b; ex_is_jump = j; ex_is_jr = r;
      ex_pc = pc; ex_imm16 = imm; ex_target26 = t26; ex_rs = rs; cmp_s = s;
   endtask

   task automatic test_reset;
      checks++; if (redir_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", redir_valid); end
      checks++; if (redir_pc !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=0", redir_pc); end
      checks++; if (ex_stall !== 1'b0 || flush !== 1'b0) begin failures++; $display("FAIL rst_stall_flush got=%0h%0h exp=00", ex_stall, flush); end
      checks++; if (addr_err !== 1'b0) begin failures++; $display("FAIL rst_addr_err got=%0h exp=0", addr_err); end
      checks++; if (br_cnt !== 0 || taken_cnt !== 0) begin failures++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", br_cnt, taken_cnt); end
   endtask

   task automatic test_taken_beq;
      present(1, 0, 0, 32'h0040_0010, 16'hFFFC, 26'h0, 32'h0, 1);
      redir_ready = 1;
      tick;
      ex_valid = 0;
      exp_br = sat(exp_br); exp_tk = sat(exp_tk);
      checks++; if (redir_valid !== 1'b1 || ex_stall !== 1'b1) begin failures++; $display("FAIL beq_valid got=%0h%0h exp=11", redir_valid, ex_stall); end
      checks++; if (redir_pc !== 32'h0040_0004) begin failures++; $display("FAIL beq_pc got=%h exp=00400004", redir_pc); end
      tick;
      checks++; if (flush !== 1'b1 || redir_valid !== 1'b0 || ex_stall !== 1'b1) begin failures++; $display("FAIL beq_flush got=%0h%0h%0h exp=101", flush, redir_valid, ex_stall); end
      tick;
      checks++; if (flush !== 1'b0 || ex_stall !== 1'b0) begin failures++; $display("FAIL beq_idle got=%0h%0h exp=00", flush, ex_stall); end
      checks++; if (br_cnt !== CW'(exp_br) || taken_cnt !== CW'(exp_tk)) begin failures++; $display("FAIL beq_cnt got=%0d/%0d exp=%0d/%0d", br_cnt, taken_cnt, exp_br, exp_tk); end
   endtask

   task automatic test_not_taken;
      present(1, 0, 0, 32'h0000_0100, 16'h0010, 26'h0, 32'h0, 0);
      tick;
      ex_valid = 0;
      exp_br = sat(exp_br);
      checks++; if (redir_valid !== 1'b0 || ex_stall !== 1'b0) begin failures++; $display("FAIL bne_nt got=%0h%0h exp=00", redir_valid, ex_stall); end
      tick;
      checks++; if (redir_valid !== 1'b0) begin failures++; $display("FAIL bne_nt2 got=%0h exp=0", redir_valid); end
      checks++; if (br_cnt !== CW'(exp_br) || taken_cnt !== CW'(exp_tk)) begin failures++; $display("FAIL bne_cnt got=%0d/%0d exp=%0d/%0d", br_cnt, taken_cnt, exp_br, exp_tk); end
   endtask

   task automatic test_backpressure;
      present(0, 1, 0, 32'hBFC0_0000, 16'h0, 26'h000_0040, 32'h0, 0);
      redir_ready = 0;
      tick;
      exp_br = sat(exp_br); exp_tk = sat(exp_tk);
      present(1, 0, 0, 32'h0000_2000, 16'h0001, 26'h0, 32'h0, 1);
      for (int i = 0; i < 3; i++) begin
         checks++; if (redir_valid !== 1'b1 || ex_stall !== 1'b1) begin failures++; $display("FAIL bp_hold%0d got=%0h%0h exp=11", i, redir_valid, ex_stall); end
         checks++; if (redir_pc !== 32'hB000_0100) begin failures++; $display("FAIL bp_pc%0d got=%h exp=b0000100", i, redir_pc); end
         if (i == 2) redir_ready = 1;
         tick;
      end
      checks++; if (flush !== 1'b1) begin failures++; $display("FAIL bp_flush got=%0h exp=1", flush); end
      ex_valid = 0;
      tick;
      checks++; if (ex_stall !== 1'b0 || redir_valid !== 1'b0) begin failures++; $display("FAIL bp_idle got=%0h%0h exp=00", ex_stall, redir_valid); end
      checks++; if (br_cnt !== CW'(exp_br) || taken_cnt !== CW'(exp_tk)) begin failures++; $display("FAIL bp_cnt got=%0d/%0d exp=%0d/%0d", br_cnt, taken_cnt, exp_br, exp_tk); end
   endtask

   task automatic test_misaligned_jr;
      present(0, 0, 1, 32'h0000_0500, 16'h0, 26'h0, 32'h0000_1003, 0);
      redir_ready = 1;
      tick;
      ex_valid = 0;
      checks++; if (addr_err !== 1'b1) begin failures++; $display("FAIL jr_err got=%0h exp=1", addr_err); end
      checks++; if (redir_pc !== 32'h0000_1000 || redir_valid !== 1'b1) begin failures++; $display("FAIL jr_pc got=%h/%0h exp=00001000/1", redir_pc, redir_valid); end
      tick;
      tick;
      checks++; if (addr_err !== 1'b1 || ex_stall !== 1'b0) begin failures++; $display("FAIL jr_sticky got=%0h%0h exp=10", addr_err, ex_stall); end
      clr_stats = 1;
      tick;
      clr_stats = 0;
      exp_br = 0; exp_tk = 0; exp_ae = 0;
      checks++; if (addr_err !== 1'b0 || br_cnt !== 0 || taken_cnt !== 0) begin failures++; $display("FAIL jr_clr got=%0h/%0d/%0d exp=0/0/0", addr_err, br_cnt, taken_cnt); end
   endtask

   task automatic test_wrap;
      present(1, 0, 0, 32'hFFFF_FFF8, 16'h0004, 26'h0, 32'h0, 1);
      redir_ready = 1;
      tick;
      ex_valid = 0;
      exp_br = sat(exp_br); exp_tk = sat(exp_tk);
      checks++; if (redir_pc !== 32'h0000_000C) begin failures++; $display("FAIL wrap_pc got=%h exp=0000000c", redir_pc); end
      tick;
      tick;
   endtask

   task automatic test_clr_priority;
      clr_stats = 1; redir_ready = 0;
      present(0, 1, 0, 32'h0000_4000, 16'h0, 26'h123, 32'h0, 0);
      tick;
      clr_stats = 0; ex_valid = 0;
      checks++; if (redir_valid !== 1'b1 || br_cnt !== 0 || taken_cnt !== 0) begin failures++; $display("FAIL clr_inc got=%0h/%0d/%0d exp=1/0/0", redir_valid, br_cnt, taken_cnt); end
      clr_stats = 1; redir_ready = 1;
      tick;
      clr_stats = 0;
      checks++; if (flush !== 1'b1 || br_cnt !== 0) begin failures++; $display("FAIL clr_hs got=%0h/%0d exp=1/0", flush, br_cnt); end
      tick;
      exp_br = 0; exp_tk = 0; exp_ae = 0;
   endtask

   task automatic test_saturation;
      redir_ready = 1;
      for (int i = 0; i < 20; i++) begin
         present(0, 1, 0, 32'(i * 16), 16'h0, 26'(i), 32'h0, 0);
         tick;
         ex_valid = 0;
         exp_br = sat(exp_br); exp_tk = sat(exp_tk);
         tick;
         tick;
      end
      checks++; if (taken_cnt !== CW'(exp_tk) || br_cnt !== CW'(exp_br) || exp_tk != MAXC) begin failures++; $display("FAIL sat_cnt got=%0d/%0d exp=%0d/%0d", br_cnt, taken_cnt, exp_br, exp_tk); end
   endtask

   task automatic test_reset_mid;
      redir_ready = 0;
      present(0, 1, 0, 32'h0000_8000, 16'h0, 26'h55, 32'h0, 0);
      tick;
      ex_valid = 0;
      checks++; if (redir_valid !== 1'b1) begin failures++; $display("FAIL rm_pre got=%0h exp=1", redir_valid); end
      #2 reset = 0;
      #1;
      checks++; if (redir_valid !== 1'b0 || ex_stall !== 1'b0 || flush !== 1'b0) begin failures++; $display("FAIL rm_pend got=%0h%0h%0h exp=000", redir_valid, ex_stall, flush); end
      checks++; if (redir_pc !== 32'h0 || br_cnt !== 0 || taken_cnt !== 0) begin failures++; $display("FAIL rm_regs got=%h/%0d/%0d exp=0/0/0", redir_pc, br_cnt, taken_cnt); end
      @(negedge clk);
      reset = 1;
      exp_br = 0; exp_tk = 0; exp_ae = 0;
      redir_ready = 1;
      present(0, 1, 0, 32'h0000_8000, 16'h0, 26'h55, 32'h0, 0);
      tick;
      ex_valid = 0;
      tick;
      checks++; if (flush !== 1'b1) begin failures++; $display("FAIL rm_fl_pre got=%0h exp=1", flush); end
      #2 reset = 0;
      #1;
      checks++; if (flush !== 1'b0 || ex_stall !== 1'b0) begin failures++; $display("FAIL rm_flush got=%0h%0h exp=00", flush, ex_stall); end
      @(negedge clk);
      reset = 1;
   endtask

   task automatic test_random;
      bit v, b, j, r, s, ctl, tk;
      logic [2:0] f;
      logic [31:0] pc, rs;
      logic [15:0] imm;
      logic [25:0] t26;
      int hold;
      for (int n = 0; n < 60; n++) begin
         v = $urandom_range(0, 3) != 0;
         f = 3'($urandom_range(0, 7));
         {b, j, r} = f;
         s = 1'($urandom);
         pc = $urandom; rs = $urandom; imm = 16'($urandom); t26 = 26'($urandom);
         ctl = v && (b || j || r);
         tk = ctl && (r || j || (b && s));
         if (ctl) exp_br = sat(exp_br);
         if (tk) begin exp_tk = sat(exp_tk); exp_pc = ref_target(j, r, pc, imm, t26, rs); end
         if (ctl && r && rs[1:0] != 2'b00) exp_ae = 1;
         present(b, j, r, pc, imm, t26, rs, s);
         ex_valid = v;
         redir_ready = 1'($urandom);
         tick;
         ex_valid = 0;
         if (tk) begin
            hold = $urandom_range(0, 2);
            for (int h = 0; h <= hold; h++) begin
               checks++; if (redir_valid !== 1'b1 || redir_pc !== exp_pc) begin failures++; $display("FAIL rnd%0d_pend got=%0h/%h exp=1/%h", n, redir_valid, redir_pc, exp_pc); end
               redir_ready = h == hold;
               tick;
            end
            for (int k = 0; k < FC; k++) begin
               checks++; if (flush !== 1'b1 || ex_stall !== 1'b1) begin failures++; $display("FAIL rnd%0d_flush got=%0h%0h exp=11", n, flush, ex_stall); end
               tick;
            end
         end
         checks++; if (redir_valid !== 1'b0 || ex_stall !== 1'b0 || flush !== 1'b0) begin failures++; $display("FAIL rnd%0d_idle got=%0h%0h%0h exp=000", n, redir_valid, ex_stall, flush); end
         checks++; if (br_cnt !== CW'(exp_br) || taken_cnt !== CW'(exp_tk) || addr_err !== exp_ae) begin failures++; $display("FAIL rnd%0d_stats got=%0d/%0d/%0h exp=%0d/%0d/%0h", n, br_cnt, taken_cnt, addr_err, exp_br, exp_tk, exp_ae); end
         if (n == 30) begin
            clr_stats = 1;
            tick;
            clr_stats = 0;
            exp_br = 0; exp_tk = 0; exp_ae = 0;
         end
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      reset = 1;
      @(negedge clk);
      test_reset;
      test_taken_beq;
      test_not_taken;
      test_backpressure;
      test_misaligned_jr;
      test_wrap;
      test_clr_priority;
      test_saturation;
      test_reset_mid;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
